// File: rtl/add8_sweep_stats.sv
// Exhaustive 8-bit adder sweeper. It presents all 65536 (A, B) operand pairs,
// lines each pair's exact sum up with the adder result DUT_LAT cycles later,
// and accumulates absolute/squared error totals, worst-case error and the
// count of erroneous samples.
module add8_sweep_stats #(
  parameter int DUT_LAT = 0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  output logic [7:0]  A_o,
  output logic [7:0]  B_o,
  input  logic [8:0]  O_i,
  output logic        busy,
  output logic        done,
  output logic [24:0] err_sum,
  output logic [33:0] sq_sum,
  output logic [8:0]  wce,
  output logic [16:0] err_cnt
);

  localparam int DEPTH = DUT_LAT + 1;

  typedef enum logic [1:0] {IDLE, SWEEP, DRAIN, DONE} state_t;

  state_t      state, state_nx;
  logic [15:0] cnt;
  logic [DEPTH-1:0] vld;
  logic [8:0]  ex [DEPTH];

  logic        launch;
  logic        issue;
  logic [8:0]  issue_ex;
  logic        tap_vld;
  logic [8:0]  tap_ex;
  logic        pending;
  logic [8:0]  d;
  logic [17:0] d_sq;

  // Issue side: what enters the delay line this cycle, and the error of the tap.
  always_comb begin
    launch   = ((state == IDLE) || (state == DONE)) && start;
    issue    = launch || (state == SWEEP);
    issue_ex = launch ? 9'd0 : ({1'b0, cnt[7:0]} + {1'b0, cnt[15:8]});
    tap_vld  = vld[DEPTH-1];
    tap_ex   = ex[DEPTH-1];
    pending  = 1'b0;
    for (int unsigned i = 0; i + 1 < DEPTH; i++) pending = pending | vld[i];
    d        = (tap_ex >= O_i) ? (tap_ex - O_i) : (O_i - tap_ex);
    d_sq     = {9'd0, d} * {9'd0, d};
  end

  // Next-state logic; DRAIN ends on the edge that accumulates the last tap.
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (launch) state_nx = SWEEP;
      SWEEP:   if (cnt == 16'hFFFF) state_nx = DRAIN;
      DRAIN:   if (tap_vld && !pending) state_nx = DONE;
      DONE:    if (launch) state_nx = SWEEP;
      default: state_nx = IDLE;
    endcase
  end

  // State register plus registered status flags.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      state <= state_nx;
      busy  <= (state_nx == SWEEP) || (state_nx == DRAIN);
      done  <= (state_nx == DONE);
    end
  end

  // Operand generator: pair 0 is driven at the launch edge, then cnt walks on.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
      A_o <= '0;
      B_o <= '0;
    end else if (launch) begin
      cnt <= 16'd1;
      A_o <= '0;
      B_o <= '0;
    end else if (state == SWEEP) begin
      cnt <= cnt + 16'd1;
      A_o <= cnt[7:0];
      B_o <= cnt[15:8];
    end
  end

  // Valid / exact-sum delay line matching the adder latency.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) ex[i] <= '0;
    end else begin
      vld[0] <= issue;
      ex[0]  <= issue_ex;
      for (int unsigned i = 1; i < DEPTH; i++) begin
        vld[i] <= vld[i-1];
        ex[i]  <= ex[i-1];
      end
    end
  end

  // Error statistics: cleared on launch, updated whenever the tap is valid.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      err_sum <= '0;
      sq_sum  <= '0;
      wce     <= '0;
      err_cnt <= '0;
    end else if (launch) begin
      err_sum <= '0;
      sq_sum  <= '0;
      wce     <= '0;
      err_cnt <= '0;
    end else if (tap_vld) begin
      err_sum <= err_sum + {16'd0, d};
      sq_sum  <= sq_sum + {16'd0, d_sq};
      if (d > wce) wce <= d;
      err_cnt <= err_cnt + {16'd0, (d != 9'd0)};
    end
  end

endmodule

// File: tb/tb_add8_sweep_stats.sv
// Bench for add8_sweep_stats: seven sweepers run side by side around stub
// adders of different error profiles and latencies, checked every cycle
// against an arithmetic model, plus literal final-value and reset checks.
module tb_add8_sweep_stats;

  logic        clk;
  logic [6:0]  rst;
  logic [6:0]  start;
  logic [7:0]  a   [7];
  logic [7:0]  b   [7];
  logic [8:0]  o   [7];
  logic [6:0]  busy;
  logic [6:0]  done;
  logic [24:0] es  [7];
  logic [33:0] ss  [7];
  logic [8:0]  wc  [7];
  logic [16:0] ec  [7];
  logic [8:0]  lut [256];

  int errors = 0;
  int checks = 0;

  longint ms [7];
  longint mq [7];
  longint mw [7];
  longint mc [7];

  // Stub modes: 0 exact, 1 bit0 forced low, 2 constant zero, 3 random errors.
  function automatic int mode_of(int i);
    case (i)
      1, 5:    return 1;
      2:       return 2;
      4, 6:    return 3;
      default: return 0;
    endcase
  endfunction

  function automatic int lat_of(int i);
    case (i)
      3, 6:    return 2;
      4:       return 1;
      default: return 0;
    endcase
  endfunction

  function automatic logic [8:0] stub_f(int m, logic [7:0] x, logic [7:0] y);
    logic [8:0] s;
    s = {1'b0, x} + {1'b0, y};
    case (m)
      0:       return s;
      1:       return {s[8:1], 1'b0};
      2:       return 9'd0;
      default: return s ^ lut[x ^ y];
    endcase
  endfunction

  function automatic logic [127:0] vec(int i);
    return {25'd0, a[i], b[i], busy[i], done[i], es[i], ss[i], wc[i], ec[i]};
  endfunction

  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_stats(input int i, input longint e_sum, input longint e_sq,
                           input longint e_w, input longint e_c);
    chk($sformatf("final err_sum u%0d", i), 128'(es[i]), 128'(e_sum));
    chk($sformatf("final sq_sum u%0d", i), 128'(ss[i]), 128'(e_sq));
    chk($sformatf("final wce u%0d", i), 128'(wc[i]), 128'(e_w));
    chk($sformatf("final err_cnt u%0d", i), 128'(ec[i]), 128'(e_c));
  endtask

  always #5 clk = ~clk;

  for (genvar g = 0; g < 7; g++) begin : inst
    localparam int L = lat_of(g);
    logic [8:0] p1, p2;
    always @(posedge clk) begin
      p1 <= stub_f(mode_of(g), a[g], b[g]);
      p2 <= p1;
    end
    if (L == 0) begin : comb_stub
      assign o[g] = stub_f(mode_of(g), a[g], b[g]);
    end else if (L == 1) begin : reg1_stub
      assign o[g] = p1;
    end else begin : reg2_stub
      assign o[g] = p2;
    end
    add8_sweep_stats #(.DUT_LAT(L)) dut (
      .clk    (clk),
      .rst    (rst[g]),
      .start  (start[g]),
      .A_o    (a[g]),
      .B_o    (b[g]),
      .O_i    (o[g]),
      .busy   (busy[g]),
      .done   (done[g]),
      .err_sum(es[g]),
      .sq_sum (ss[g]),
      .wce    (wc[g]),
      .err_cnt(ec[g])
    );
  end

  initial begin
    clk   = 1'b0;
    rst   = '1;
    start = '0;
    for (int i = 0; i < 256; i++)
      lut[i] = ($urandom_range(0, 1) != 0) ? 9'($urandom_range(1, 511)) : 9'd0;
    for (int i = 0; i < 7; i++) begin
      ms[i] = 0; mq[i] = 0; mw[i] = 0; mc[i] = 0;
    end
    repeat (2) @(negedge clk);
    for (int i = 0; i < 7; i++) chk($sformatf("reset u%0d", i), vec(i), '0);
    rst = '0;
    @(negedge clk);
    start = '1;
    @(posedge clk);

    fork
      // Per-cycle comparison against the arithmetic model.
      begin
        int e;
        e = 0;
        forever begin
          int p;
          logic eb;
          @(negedge clk);
          p = (e > 65535) ? 65535 : e;
          for (int i = 0; i < 7; i++) begin
            if (i != 5) begin
              eb = (e < 65536 + lat_of(i));
              chk($sformatf("cycle u%0d e%0d", i, e), vec(i),
                  {25'd0, 8'(p), 8'(p >> 8), eb, !eb, 25'(ms[i]), 34'(mq[i]),
                   9'(mw[i]), 17'(mc[i])});
            end
          end
          if (e == 0) begin
            start[0] = 1'b0; start[1] = 1'b0; start[2] = 1'b0; start[3] = 1'b0;
            start[4] = 1'b0; start[6] = 1'b0;
          end
          if (e == 1000) begin
            start[0] = 1'b1; start[4] = 1'b1; start[6] = 1'b1;
          end
          if (e == 1001) begin
            start[0] = 1'b0; start[4] = 1'b0; start[6] = 1'b0;
          end
          if (e == 65539) break;
          @(posedge clk);
          e++;
          for (int i = 0; i < 7; i++) begin
            int k;
            int s;
            int f;
            int dd;
            k = e - 1 - lat_of(i);
            if (k >= 0 && k <= 65535) begin
              s  = (k & 255) + (k >> 8);
              f  = int'(stub_f(mode_of(i), 8'(k), 8'(k >> 8)));
              dd = (s > f) ? s - f : f - s;
              ms[i] += dd;
              mq[i] += longint'(dd) * dd;
              if (dd > mw[i]) mw[i] = dd;
              if (dd != 0) mc[i]++;
            end
          end
        end
      end
      // Mid-sweep reset on u5, then a fresh full sweep.
      begin
        int n;
        repeat (3000) @(negedge clk);
        start[5] = 1'b0;
        chk("u5 busy before rst", 128'(busy[5]), 128'd1);
        rst[5] = 1'b1;
        #1;
        chk("u5 outputs in rst", vec(5), '0);
        @(negedge clk);
        chk("u5 idle after rst", vec(5), '0);
        rst[5] = 1'b0;
        @(negedge clk);
        start[5] = 1'b1;
        @(negedge clk);
        start[5] = 1'b0;
        n = 0;
        while (!done[5] && n < 70000) begin
          @(negedge clk);
          n++;
        end
        chk("u5 done within bound", 128'(done[5]), 128'd1);
      end
    join

    chk_stats(0, 0, 0, 0, 0);
    chk_stats(1, 32768, 32768, 1, 32768);
    chk_stats(2, 16711680, 64'd4977295360, 510, 65535);
    chk_stats(3, 0, 0, 0, 0);
    chk_stats(5, 32768, 32768, 1, 32768);
    chk("model u1 err_sum", 128'(ms[1]), 128'd32768);
    chk("model u2 sq_sum", 128'(mq[2]), 128'd4977295360);

    // DONE -> SWEEP restart on u2: statistics clear at the start edge.
    @(negedge clk);
    start[2] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start[2] = 1'b0;
    chk("u2 restart e0", vec(2), {25'd0, 8'd0, 8'd0, 1'b1, 1'b0, 25'd0, 34'd0, 9'd0, 17'd0});
    @(negedge clk);
    chk("u2 restart e1", vec(2), {25'd0, 8'd1, 8'd0, 1'b1, 1'b0, 25'd0, 34'd0, 9'd0, 17'd0});
    @(negedge clk);
    chk("u2 restart e2", vec(2), {25'd0, 8'd2, 8'd0, 1'b1, 1'b0, 25'd1, 34'd1, 9'd1, 17'd1});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
